// File: rtl/imem_loader_pkg.sv
// Shared instruction-memory constants and the loader FSM state encoding.
package imem_pkg;

  localparam int IMEM_ADDR_W = 11;
  localparam int IMEM_DEPTH  = 2048;
  localparam int IMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word assembler: the first byte lands in bits [7:0].
module byte_packer #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [DATA_W-1:0] word_o,
  output logic              last_o
);

  localparam int NBYTES = DATA_W / 8;
  localparam int CNT_W  = $clog2(NBYTES);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] word_q, word_d;

  // Only the byte counter is cleared; stale data is overwritten before reuse.
  always_comb begin
    cnt_d  = cnt_q;
    word_d = word_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (shift_i) begin
      for (int i = 0; i < NBYTES; i++) begin
        if (cnt_q == CNT_W'(i)) begin
          word_d[i*8 +: 8] = byte_i;
        end
      end
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;
  assign last_o = (cnt_q == CNT_W'(NBYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader FSM.
// Optional IMEM_LOADER_CHECKSUM_EN adds an XOR checksum output of the written words.
module imem_loader
  import imem_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int DATA_W = IMEM_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   word_count,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [7:0]        in_data,
  output logic              in_ready,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
`ifdef IMEM_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] chksum
`endif
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  loader_state_e     state_q, state_d;
  logic [ADDR_W:0]   total_q, total_d;
  logic [ADDR_W:0]   written_q, written_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  logic              accept;
  logic              pack_last;
  logic [DATA_W-1:0] pack_word;

  assign accept = (state_q == ST_COLLECT) && in_valid;

  byte_packer #(
    .DATA_W(DATA_W)
  ) u_packer (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q == ST_IDLE || abort),
    .shift_i(accept && !abort),
    .byte_i (in_data),
    .word_o (pack_word),
    .last_o (pack_last)
  );

  // abort wins over byte acceptance and WRITE; the address stops at the last word so it never wraps.
  always_comb begin
    state_d   = state_q;
    total_d   = total_q;
    written_d = written_q;
    addr_d    = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          total_d   = (word_count > DEPTH) ? DEPTH : word_count;
          written_d = '0;
          addr_d    = '0;
          state_d   = (word_count == '0) ? ST_DONE : ST_COLLECT;
        end
      end
      ST_COLLECT: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && pack_last) begin
          state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else begin
          written_d = written_q + 1'b1;
          if (written_d == total_q) begin
            state_d = ST_DONE;
          end else begin
            addr_d  = addr_q + 1'b1;
            state_d = ST_COLLECT;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      total_q   <= '0;
      written_q <= '0;
      addr_q    <= '0;
    end else begin
      state_q   <= state_d;
      total_q   <= total_d;
      written_q <= written_d;
      addr_q    <= addr_d;
    end
  end

  assign in_ready = (state_q == ST_COLLECT);
  assign wr_en    = (state_q == ST_WRITE);
  assign busy     = (state_q == ST_COLLECT) || (state_q == ST_WRITE);
  assign done     = (state_q == ST_DONE);
  assign wr_addr  = addr_q;
  assign wr_data  = pack_word;

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0] chksum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chksum_q <= '0;
    end else if (state_q == ST_IDLE && start) begin
      chksum_q <= '0;
    end else if (state_q == ST_WRITE) begin
      chksum_q <= chksum_q ^ pack_word;
    end
  end

  assign chksum = chksum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed, table-driven bench for imem_loader; covers the checksum port when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] word_count;
  logic        abort;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic        wr_en;
  logic [10:0] wr_addr;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] chksum;
`endif

  imem_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .word_count(word_count),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    .chksum    (chksum)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [11:0] wordCount;
    logic [31:0] seed;
    bit          gap;
    int          expWrites;
  } vec_t;

  int          nChecks = 0;
  int          nFails = 0;
  int          wrCount = 0;
  int          doneCount = 0;
  int          expLimit = 0;
  logic [31:0] expWords [0:2047];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every write is checked against the expected word list, and done pulses are counted.
  always @(negedge clk) begin
    if (!rst && wr_en) begin
      if (wrCount >= expLimit) begin
        nChecks++;
        nFails++;
        $display("[TB] FAIL unexpected write: got addr 0x%03h, expected no write at %0t", wr_addr, $time);
      end else begin
        checkOutput("wr_addr", 32'(wr_addr), 32'(wrCount));
        checkOutput("wr_data", wr_data, expWords[wrCount]);
        checkOutput("in_ready during WRITE", 32'(in_ready), 32'd0);
      end
      wrCount++;
    end
    if (!rst && done) begin
      doneCount++;
      checkOutput("busy at done", 32'(busy), 32'd0);
    end
  end

  task automatic startLoad(input logic [11:0] count);
    start      = 1'b1;
    word_count = count;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Holds the byte until it is accepted; an optional idle cycle afterwards toggles in_valid.
  task automatic sendByte(input logic [7:0] b, input bit gap);
    bit acc = 1'b0;
    int t = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!acc && t < 50) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      t++;
    end
    in_valid = 1'b0;
    if (!acc) begin
      nChecks++;
      nFails++;
      $display("[TB] FAIL byte accept timeout: got in_ready 0, expected 1 within 50 cycles");
    end
    if (gap) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic waitDone();
    int t = 0;
    while (doneCount == 0 && t < 20) begin
      @(posedge clk);
      t++;
    end
    #1;
    checkOutput("done pulse count", 32'(doneCount), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("done clears", 32'(done), 32'd0);
  endtask

  task automatic applyStimulus(input vec_t v);
    logic [31:0] xorModel = '0;
    for (int i = 0; i < v.expWrites; i++) begin
      expWords[i] = v.seed + 32'(i) * 32'h0001_0001;
      xorModel    = xorModel ^ expWords[i];
    end
    wrCount   = 0;
    doneCount = 0;
    expLimit  = v.expWrites;
    startLoad(v.wordCount);
    for (int i = 0; i < v.expWrites; i++) begin
      for (int b = 0; b < 4; b++) begin
        sendByte(expWords[i][b*8 +: 8], v.gap);
      end
    end
    waitDone();
    checkOutput("write count", 32'(wrCount), 32'(v.expWrites));
    checkOutput("busy after load", 32'(busy), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    checkOutput("chksum", chksum, xorModel);
`endif
  endtask

  vec_t vecs [0:4];

  initial begin
    vecs[0] = '{wordCount: 12'd3,    seed: 32'hA5A5_A5A5, gap: 1'b1, expWrites: 3};
    vecs[1] = '{wordCount: 12'd2,    seed: 32'h0000_0000, gap: 1'b0, expWrites: 2};
    vecs[2] = '{wordCount: 12'd0,    seed: 32'h1111_1111, gap: 1'b0, expWrites: 0};
    vecs[3] = '{wordCount: 12'd5,    seed: 32'hFFFF_FFFF, gap: 1'b1, expWrites: 5};
    vecs[4] = '{wordCount: 12'd4095, seed: 32'hDEAD_0000, gap: 1'b0, expWrites: 2048};

    rst        = 1'b1;
    start      = 1'b0;
    word_count = '0;
    abort      = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset in_ready", 32'(in_ready), 32'd0);
    checkOutput("reset wr_en", 32'(wr_en), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    checkOutput("reset wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("reset wr_data", wr_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Single word, back-to-back bytes: write the cycle after the 4th byte, done one cycle later.
    expWords[0] = 32'h1234_5678;
    wrCount = 0; doneCount = 0; expLimit = 1;
    startLoad(12'd1);
    sendByte(8'h78, 1'b0);
    sendByte(8'h56, 1'b0);
    sendByte(8'h34, 1'b0);
    sendByte(8'h12, 1'b0);
    @(negedge clk);
    checkOutput("single wr_en", 32'(wr_en), 32'd1);
    checkOutput("single wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("single wr_data", wr_data, 32'h1234_5678);
    checkOutput("single busy in WRITE", 32'(busy), 32'd1);
    @(negedge clk);
    checkOutput("single done", 32'(done), 32'd1);
    checkOutput("single wr_en after", 32'(wr_en), 32'd0);
    @(negedge clk);
    checkOutput("single done clears", 32'(done), 32'd0);
    checkOutput("single done count", 32'(doneCount), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i]);
    end

    // Abort after two bytes of word 5, with a byte offered on the abort cycle.
    for (int i = 0; i < 8; i++) expWords[i] = 32'hC0DE_0000 + 32'(i);
    wrCount = 0; doneCount = 0; expLimit = 5;
    startLoad(12'd8);
    for (int i = 0; i < 5; i++) begin
      for (int b = 0; b < 4; b++) sendByte(expWords[i][b*8 +: 8], 1'b0);
    end
    sendByte(8'h05, 1'b0);
    sendByte(8'h00, 1'b0);
    abort    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hDE;
    @(posedge clk);
    #1;
    abort    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort in_ready", 32'(in_ready), 32'd0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("abort writes", 32'(wrCount), 32'd5);
    checkOutput("abort no done", 32'(doneCount), 32'd0);
    applyStimulus('{wordCount: 12'd1, seed: 32'hBEEF_0001, gap: 1'b0, expWrites: 1});

    // Reset asserted while in WRITE.
    expWords[0] = 32'h0BAD_F00D;
    wrCount = 0; doneCount = 0; expLimit = 0;
    startLoad(12'd4);
    for (int b = 0; b < 4; b++) sendByte(expWords[0][b*8 +: 8], 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid-write rst wr_en", 32'(wr_en), 32'd0);
    checkOutput("mid-write rst busy", 32'(busy), 32'd0);
    checkOutput("mid-write rst in_ready", 32'(in_ready), 32'd0);
    checkOutput("mid-write rst done", 32'(done), 32'd0);
    checkOutput("mid-write rst wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("mid-write rst wr_data", wr_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("post-rst writes", 32'(wrCount), 32'd0);
    checkOutput("post-rst busy", 32'(busy), 32'd0);

    // A start with word_count 0 while busy must not end the load.
    startLoad(12'd2);
    sendByte(8'hAA, 1'b0);
    startLoad(12'd0);
    @(negedge clk);
    checkOutput("start ignored busy", 32'(busy), 32'd1);
    checkOutput("start ignored no done", 32'(doneCount), 32'd0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;

    // Zero-length load: done with no write.
    doneCount = 0;
    startLoad(12'd0);
    @(negedge clk);
    checkOutput("zero-length done", 32'(done), 32'd1);
    checkOutput("zero-length wr_en", 32'(wr_en), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("zero-length writes", 32'(wrCount), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    expWords[0] = 32'hFFFF_0000;
    expWords[1] = 32'h0000_FFFF;
    wrCount = 0; doneCount = 0; expLimit = 2;
    startLoad(12'd2);
    for (int i = 0; i < 2; i++) begin
      for (int b = 0; b < 4; b++) sendByte(expWords[i][b*8 +: 8], 1'b0);
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("chksum done pulse", 32'(done), 32'd1);
    checkOutput("chksum at done", chksum, 32'hFFFF_FFFF);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("chksum stable", chksum, 32'hFFFF_FFFF);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
